intersection_controller: RTL

Sequences two traffic-light heads at one junction: direction A and the crossing direction B. The two heads are never green or yellow at the same time. Vehicle sensors and a pedestrian push-button shorten greens and insert a walk phase. Sits above the per-head light logic and drives its red/yellow/green lines directly. Single clock domain, pausable via enable.

---
 rtl/tl_pkg.sv | 46 ++++
 rtl/intersection_controller_if.sv | 26 ++
 rtl/tl_phase_timer.sv | 24 ++
 rtl/intersection_controller.sv | 110 +++++++++++
 4 files changed

// File: rtl/tl_pkg.sv
// Shared types and default timing for the intersection controller.
// Phase codes double as the debug encoding exported on the phase port.
package tl_pkg;

  typedef enum logic [2:0] {
    RED_A = 3'd0,
    GRN_A = 3'd1,
    YEL_A = 3'd2,
    RED_B = 3'd3,
    GRN_B = 3'd4,
    YEL_B = 3'd5,
    WALK  = 3'd6
  } state_e;

  typedef enum logic {
    DIR_A = 1'b0,
    DIR_B = 1'b1
  } dir_e;

  typedef struct packed {
    logic red;
    logic yellow;
    logic green;
  } lamp_t;

  localparam lamp_t LAMP_RED    = 3'b100;
  localparam lamp_t LAMP_YELLOW = 3'b010;
  localparam lamp_t LAMP_GREEN  = 3'b001;

  localparam int DEF_MIN_GREEN     = 4;
  localparam int DEF_MAX_GREEN     = 8;
  localparam int DEF_YELLOW_CYCLES = 2;
  localparam int DEF_ALLRED_CYCLES = 1;
  localparam int DEF_WALK_CYCLES   = 3;
  localparam int DEF_TW            = 8;

  // A head is red in every state except its own green and yellow.
  function automatic lamp_t lamp_for(state_e s, state_e grn, state_e yel);
    lamp_t l;
    l = LAMP_RED;
    if (s == grn)      l = LAMP_GREEN;
    else if (s == yel) l = LAMP_YELLOW;
    return l;
  endfunction

endpackage

// File: rtl/intersection_controller_if.sv
// Request and lamp bundle between the junction controller and its surroundings.
// slave is the controller side; master is the sensor/lamp side.
interface intersection_controller_if;
  logic       enable;
  logic       car_a;
  logic       car_b;
  logic       ped_req;
  logic       a_red;
  logic       a_yellow;
  logic       a_green;
  logic       b_red;
  logic       b_yellow;
  logic       b_green;
  logic       walk;
  logic [2:0] phase;

  modport master (
    output enable, car_a, car_b, ped_req,
    input  a_red, a_yellow, a_green, b_red, b_yellow, b_green, walk, phase
  );

  modport slave (
    input  enable, car_a, car_b, ped_req,
    output a_red, a_yellow, a_green, b_red, b_yellow, b_green, walk, phase
  );
endinterface

// File: rtl/tl_phase_timer.sv
// Phase timer: counts enabled cycles spent in the current state.
// done flags the last enabled cycle of a phase lasting duration cycles.
module tl_phase_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          advance,
  input  logic [TW:0]   duration,
  output logic [TW-1:0] count,
  output logic          done
);

  // duration is one bit wider than count so that 2^TW is representable.
  assign done = advance && ({1'b0, count} == (duration - (TW+1)'(1)));

  // NOTE: sequential state is always assigned with <= so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset)        count <= '0;
    else if (advance) count <= clear ? '0 : count + TW'(1);
  end

endmodule

// File: rtl/intersection_controller.sv
// Two-head junction sequencer with demand-shortened greens and a pedestrian walk phase.
// Lamps are registered from the next-state decode so they change on the same edge as the state.
module intersection_controller
  import tl_pkg::*;
#(
  parameter int MIN_GREEN     = DEF_MIN_GREEN,
  parameter int MAX_GREEN     = DEF_MAX_GREEN,
  parameter int YELLOW_CYCLES = DEF_YELLOW_CYCLES,
  parameter int ALLRED_CYCLES = DEF_ALLRED_CYCLES,
  parameter int WALK_CYCLES   = DEF_WALK_CYCLES,
  parameter int TW            = DEF_TW
) (
  input logic                      clk,
  input logic                      reset,
  intersection_controller_if.slave bus
);

  localparam logic [TW:0]   D_ALLRED = (TW+1)'(ALLRED_CYCLES);
  localparam logic [TW:0]   D_GREEN  = (TW+1)'(MAX_GREEN);
  localparam logic [TW:0]   D_YELLOW = (TW+1)'(YELLOW_CYCLES);
  localparam logic [TW:0]   D_WALK   = (TW+1)'(WALK_CYCLES);
  localparam logic [TW-1:0] MIN_LAST = TW'(MIN_GREEN - 1);

  state_e        state;
  state_e        next_state;
  dir_e          last_dir;
  logic          pend_a;
  logic          pend_b;
  logic          ped_pend;
  logic [TW:0]   duration;
  logic [TW-1:0] timer_count;
  logic          done;
  logic          green_min;
  lamp_t         lamp_a;
  lamp_t         lamp_b;
  logic          walk_q;

  tl_phase_timer #(.TW(TW)) u_timer (
    .clk      (clk),
    .reset    (reset),
    .clear    (next_state != state),
    .advance  (bus.enable),
    .duration (duration),
    .count    (timer_count),
    .done     (done)
  );

  assign green_min = timer_count >= MIN_LAST;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    duration = D_ALLRED;
    unique case (state)
      GRN_A, GRN_B: duration = D_GREEN;
      YEL_A, YEL_B: duration = D_YELLOW;
      WALK:         duration = D_WALK;
      default:      duration = D_ALLRED;
    endcase
  end

  always_comb begin
    next_state = state;
    if (bus.enable) begin
      unique case (state)
        RED_A: if (done) next_state = GRN_A;
        GRN_A: if (done || (green_min && (pend_b || ped_pend))) next_state = YEL_A;
        YEL_A: if (done) next_state = ped_pend ? WALK : RED_B;
        RED_B: if (done) next_state = GRN_B;
        GRN_B: if (done || (green_min && (pend_a || ped_pend))) next_state = YEL_B;
        YEL_B: if (done) next_state = ped_pend ? WALK : RED_A;
        WALK:  if (done) next_state = (last_dir == DIR_A) ? RED_B : RED_A;
        default: next_state = RED_A;
      endcase
    end
  end

  // Demand latches run even while paused; clearing on green/walk entry beats a same-edge request.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RED_A;
      last_dir <= DIR_B;
      pend_a   <= 1'b0;
      pend_b   <= 1'b0;
      ped_pend <= 1'b0;
      lamp_a   <= LAMP_RED;
      lamp_b   <= LAMP_RED;
      walk_q   <= 1'b0;
    end else begin
      state <= next_state;
      if (state == YEL_A && next_state != YEL_A) last_dir <= DIR_A;
      if (state == YEL_B && next_state != YEL_B) last_dir <= DIR_B;
      pend_a   <= (next_state == GRN_A && state != GRN_A) ? 1'b0 : (pend_a   | bus.car_a);
      pend_b   <= (next_state == GRN_B && state != GRN_B) ? 1'b0 : (pend_b   | bus.car_b);
      ped_pend <= (next_state == WALK  && state != WALK)  ? 1'b0 : (ped_pend | bus.ped_req);
      lamp_a   <= lamp_for(next_state, GRN_A, YEL_A);
      lamp_b   <= lamp_for(next_state, GRN_B, YEL_B);
      walk_q   <= (next_state == WALK);
    end
  end

  assign bus.a_red    = lamp_a.red;
  assign bus.a_yellow = lamp_a.yellow;
  assign bus.a_green  = lamp_a.green;
  assign bus.b_red    = lamp_b.red;
  assign bus.b_yellow = lamp_b.yellow;
  assign bus.b_green  = lamp_b.green;
  assign bus.walk     = walk_q;
  assign bus.phase    = state;

endmodule
